// File: rtl/reg_wr_arbiter.sv
// Register-file write-port arbiter between pipeline writeback and a multi-cycle unit,
// with a one-entry result buffer, starvation stall and a pending-result scoreboard.
module reg_wr_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_addr,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        w_en,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data,
    input  logic [4:0]  r1_addr,
    input  logic [4:0]  r2_addr,
    output logic        r1_busy,
    output logic        r2_busy,
    output logic        stall_req
);

    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 3;
    localparam int unsigned NREG = 32;

    logic            hold_valid_q, hold_valid_d;
    logic [AW-1:0]   hold_addr_q,  hold_addr_d;
    logic [DW-1:0]   hold_data_q,  hold_data_d;
    logic [CW-1:0]   wait_cnt_q,   wait_cnt_d;
    logic [NREG-1:0] pending_q,    pending_d;

    logic wb_req_c, starved_c, stall_c, drain_c, accept_c;

    // Arbitration: a starved buffer pre-empts writeback, otherwise writeback wins.
    always_comb begin
        wb_req_c  = wb_en && (wb_addr != '0);
        starved_c = hold_valid_q && (wait_cnt_q == CW'(STARVE_MAX));
        stall_c   = starved_c && wb_req_c;
        drain_c   = hold_valid_q && (stall_c || !wb_req_c);
        accept_c  = md_valid && !hold_valid_q;
    end

    // Next state for buffer, starvation counter and scoreboard.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        wait_cnt_d   = wait_cnt_q;
        pending_d    = pending_q;

        if (accept_c) begin
            // A result for r0 is swallowed: nothing to write.
            hold_valid_d = (md_addr != '0);
            hold_addr_d  = md_addr;
            hold_data_d  = md_data;
        end else if (drain_c) begin
            hold_valid_d = 1'b0;
        end

        if (!hold_valid_q || drain_c) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != CW'(STARVE_MAX)) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end

        if (drain_c) begin
            pending_d[hold_addr_q] = 1'b0;
        end
        // Set after clear so a same-cycle reissue keeps the register busy.
        if (md_issue && (md_issue_addr != '0)) begin
            pending_d[md_issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            wait_cnt_q   <= '0;
            pending_q    <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            wait_cnt_q   <= wait_cnt_d;
            pending_q    <= pending_d;
        end
    end

    // Combinational outputs, all held at zero while reset is asserted.
    always_comb begin
        w_en      = 1'b0;
        w_addr    = '0;
        w_data    = '0;
        md_ready  = 1'b0;
        stall_req = 1'b0;
        r1_busy   = 1'b0;
        r2_busy   = 1'b0;
        if (!rst) begin
            md_ready  = !hold_valid_q;
            stall_req = stall_c;
            r1_busy   = pending_q[r1_addr];
            r2_busy   = pending_q[r2_addr];
            if (drain_c) begin
                w_en   = 1'b1;
                w_addr = hold_addr_q;
                w_data = hold_data_q;
            end else if (wb_req_c) begin
                w_en   = 1'b1;
                w_addr = wb_addr;
                w_data = wb_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed self-checking bench for reg_wr_arbiter (STARVE_MAX = 4).
`timescale 1ns/1ps
module tb_reg_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_issue;
    logic [4:0]  md_issue_addr;
    logic        md_valid;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        md_ready;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  r1_addr;
    logic [4:0]  r2_addr;
    logic        r1_busy;
    logic        r2_busy;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    reg_wr_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_issue(md_issue), .md_issue_addr(md_issue_addr),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data),
        .md_ready(md_ready),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .r1_addr(r1_addr), .r2_addr(r2_addr),
        .r1_busy(r1_busy), .r2_busy(r2_busy),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start of a new cycle: just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #2;
    endtask

    task automatic idle();
        wb_en = 0; wb_addr = 0; wb_data = 0;
        md_issue = 0; md_issue_addr = 0;
        md_valid = 0; md_addr = 0; md_data = 0;
    endtask

    task automatic chk_port(input string tag, input logic en, input logic [4:0] a,
                            input logic [31:0] d, input logic st);
        chk({tag, "_wen"},   32'(w_en), 32'(en));
        chk({tag, "_waddr"}, 32'(w_addr), 32'(a));
        chk({tag, "_wdata"}, w_data, d);
        chk({tag, "_stall"}, 32'(stall_req), 32'(st));
    endtask

    initial begin
        // Reset with active requests: everything forced low.
        rst = 1; idle();
        wb_en = 1; wb_addr = 5; wb_data = 32'h55;
        md_valid = 1; md_addr = 4; md_data = 32'h44;
        md_issue = 1; md_issue_addr = 4;
        r1_addr = 4; r2_addr = 5;
        settle();
        chk_port("rst0", 0, 0, 0, 0);
        chk("rst0_rdy", 32'(md_ready), 0);
        chk("rst0_b1", 32'(r1_busy), 0);
        chk("rst0_b2", 32'(r2_busy), 0);
        tick(); settle();
        chk_port("rst1", 0, 0, 0, 0);
        chk("rst1_rdy", 32'(md_ready), 0);
        chk("rst1_b1", 32'(r1_busy), 0);
        tick(); rst = 0; idle(); settle();
        chk("rel_rdy", 32'(md_ready), 1);
        chk_port("rel", 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            r1_addr = 5'(i); r2_addr = 5'(31 - i);
            settle();
            chk("rel_pend1", 32'(r1_busy), 0);
            chk("rel_pend2", 32'(r2_busy), 0);
            tick();
        end

        // Writeback pass-through.
        wb_en = 1; wb_addr = 5; wb_data = 32'h0000_1234; settle();
        chk_port("wb", 1, 5, 32'h0000_1234, 0);

        // Scoreboard + result drain for r7.
        tick(); idle(); md_issue = 1; md_issue_addr = 7; r1_addr = 7; settle();
        chk("sb_c0_busy", 32'(r1_busy), 0);
        tick(); idle(); settle();
        chk("sb_c1_busy", 32'(r1_busy), 1);
        tick(); md_valid = 1; md_addr = 7; md_data = 32'hDEAD_BEEF; settle();
        chk("sb_c2_rdy", 32'(md_ready), 1);
        chk_port("sb_c2", 0, 0, 0, 0);
        tick(); idle(); settle();
        chk_port("sb_c3", 1, 7, 32'hDEAD_BEEF, 0);
        chk("sb_c3_rdy", 32'(md_ready), 0);
        chk("sb_c3_busy", 32'(r1_busy), 1);
        tick(); settle();
        chk("sb_c4_busy", 32'(r1_busy), 0);
        chk("sb_c4_rdy", 32'(md_ready), 1);
        chk_port("sb_c4", 0, 0, 0, 0);

        // Starvation: r9 held while writeback to r10 runs every cycle.
        tick(); idle(); md_issue = 1; md_issue_addr = 9; r2_addr = 9;
        md_valid = 1; md_addr = 9; md_data = 32'h0000_0099; settle();
        for (int k = 1; k <= 4; k++) begin
            tick(); idle(); wb_en = 1; wb_addr = 10; wb_data = 32'h100 + 32'(k); settle();
            chk_port("stv_win", 1, 10, 32'h100 + 32'(k), 0);
            chk("stv_rdy", 32'(md_ready), 0);
            chk("stv_busy", 32'(r2_busy), 1);
        end
        tick(); wb_data = 32'h200; settle();
        chk_port("stv_c5", 1, 9, 32'h0000_0099, 1);
        tick(); settle();
        chk_port("stv_c6", 1, 10, 32'h200, 0);
        chk("stv_c6_rdy", 32'(md_ready), 1);
        chk("stv_c6_busy", 32'(r2_busy), 0);

        // Same-cycle issue and drain of r3: set wins.
        tick(); idle(); md_issue = 1; md_issue_addr = 3; r1_addr = 3; settle();
        tick(); idle(); md_valid = 1; md_addr = 3; md_data = 32'h33; settle();
        tick(); idle(); md_issue = 1; md_issue_addr = 3; settle();
        chk_port("iss_drn", 1, 3, 32'h33, 0);
        tick(); idle(); settle();
        chk("iss_drn_busy", 32'(r1_busy), 1);
        md_valid = 1; md_addr = 3; md_data = 32'h34;
        tick(); idle(); settle();
        chk_port("iss_drn2", 1, 3, 32'h34, 0);
        tick(); settle();
        chk("iss_drn2_busy", 32'(r1_busy), 0);

        // r0 cases.
        md_valid = 1; md_addr = 12; md_data = 32'hC0C0;
        tick(); idle(); wb_en = 1; wb_addr = 0; wb_data = 32'hBAD0; settle();
        chk_port("r0_wb", 1, 12, 32'hC0C0, 0);
        tick(); idle(); md_issue = 1; md_issue_addr = 0; r1_addr = 0; settle();
        chk("r0_rdy", 32'(md_ready), 1);
        tick(); idle(); md_valid = 1; md_addr = 0; md_data = 32'hFFFF; settle();
        chk("r0_iss_busy", 32'(r1_busy), 0);
        tick(); idle(); settle();
        chk("r0_res_rdy", 32'(md_ready), 1);
        chk_port("r0_res", 0, 0, 0, 0);

        // Reset mid-operation discards held result and pending bits.
        md_issue = 1; md_issue_addr = 13; r1_addr = 13;
        tick(); idle(); md_valid = 1; md_addr = 13; md_data = 32'h1313; settle();
        tick(); idle(); wb_en = 1; wb_addr = 14; wb_data = 32'h1414; settle();
        chk_port("mid_pre", 1, 14, 32'h1414, 0);
        chk("mid_pre_busy", 32'(r1_busy), 1);
        rst = 1; settle();
        chk_port("mid_rst", 0, 0, 0, 0);
        tick(); rst = 0; idle(); settle();
        chk("mid_rdy", 32'(md_ready), 1);
        chk("mid_busy", 32'(r1_busy), 0);
        chk_port("mid_post", 0, 0, 0, 0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Arbitrates the register file's single write port between the pipeline writeback stage and a multi-cycle execution unit such as a multiplier/divider. The multi-cycle result is held in a one-entry buffer and written whenever writeback leaves the port free. A starvation counter forces a writeback stall when that result has waited too long. A 32-entry pending scoreboard reports which registers still await a multi-cycle result, for use by the hazard/stall logic.

## Interface
- STARVE_MAX, 4: cycles a held result may lose arbitration before `stall_req` is forced (1..7).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_en  in  1  writeback write request.
- wb_addr  in  5  writeback destination register.
- wb_data  in  32  writeback data.
- md_issue  in  1  a multi-cycle op to `md_issue_addr` was issued this cycle.
- md_issue_addr  in  5  destination of the issued multi-cycle op.
- md_valid  in  1  multi-cycle result valid.
- md_addr  in  5  result destination register.
- md_data  in  32  result data.
- md_ready  out  1  result accepted at this edge when `md_valid` is also 1.
- w_en  out  1  register file write enable.
- w_addr  out  5  register file write address.
- w_data  out  32  register file write data.
- r1_addr, r2_addr  in  5 each  source registers to check.
- r1_busy, r2_busy  out  1 each  the source register has a pending multi-cycle result.
- stall_req  out  1  the writeback stage must hold its request and retry next cycle.

## Operation
- Internal state:
  - `hold_valid`, `hold_addr`, `hold_data` (one-entry result buffer).
  - `wait_cnt` (3 bits, saturating at STARVE_MAX).
  - `pending[31:0]` (scoreboard).
- `wb_req = wb_en && wb_addr != 0`. `starved = hold_valid && wait_cnt == STARVE_MAX`.
- Write-port select (combinational), in priority order:
  - `starved && wb_req`: write the hold buffer. `stall_req` = 1 and the writeback request is not written.
  - `wb_req`: write the writeback request.
  - `hold_valid`: write the hold buffer (drain).
  - Otherwise: `w_en` = 0, `w_addr` = 0, `w_data` = 0.
- `stall_req` = `starved && wb_req`. While `stall_req` is high, the pipeline keeps `wb_en`, `wb_addr` and `wb_data` stable into the next cycle.
- Buffer:
  - `md_ready` = !`hold_valid`.
  - On `md_valid && md_ready`, load the buffer.
  - A drain clears `hold_valid` at the edge. No accept and drain of the buffer can happen in the same cycle.
  - A result with `md_addr` = 0 is accepted and discarded: `hold_valid` stays 0.
- `wait_cnt`:
  - Cleared when the buffer is empty or drains.
  - Otherwise increments each cycle the buffer loses arbitration, saturating at STARVE_MAX.
- Scoreboard:
  - `md_issue` with a nonzero address sets `pending[md_issue_addr]`.
  - A drain clears `pending[hold_addr]`.
  - If a set and a clear hit the same address in the same cycle, the set wins.
  - `pending[0]` is constantly 0.
- `rN_busy` = `pending[rN_addr]`, combinational.
- Upstream contract: the hazard logic never issues a second multi-cycle op to a register while it is busy.

## Timing
- Reset (`rst` = 1 at an edge) clears `hold_valid`, `wait_cnt` and `pending`. While `rst` is high, all outputs are forced to 0: `w_en`, `w_addr`, `w_data`, `md_ready`, `stall_req`, `r1_busy`, `r2_busy`.
- Reset mid-operation discards the held result and all pending bits with no write.
- Writeback-to-port latency: 0 cycles (combinational pass-through).
- Result latency: accepted at edge N; earliest `w_en` is in cycle N+1; `md_ready` returns to 1 in the cycle after the drain.
- Busy latency: `md_issue` in cycle N gives busy = 1 from cycle N+1. A drain in cycle M gives busy = 0 from cycle M+1.
- Worst-case hold latency under continuous writeback: STARVE_MAX lost cycles, then a forced write in the next cycle.

## Test plan
- Reset: `rst` = 1 for 2 cycles with `wb_en` = 1, `md_valid` = 1 -> `w_en`, `md_ready`, `stall_req` and both busy outputs are 0. After release, `md_ready` = 1 and `pending` is all 0.
- Writeback only: `wb_en` = 1, `wb_addr` = 5, `wb_data` = 0x00001234 -> same cycle `w_en` = 1, `w_addr` = 5, `w_data` = 0x00001234, `stall_req` = 0.
- Scoreboard: `md_issue` to r7 in cycle 0 with `r1_addr` = 7 -> `r1_busy` = 1 from cycle 1.
  - Result (r7, 0xDEADBEEF) accepted at the edge ending cycle 2, writeback idle -> cycle 3 writes r7 with 0xDEADBEEF.
  - `r1_busy` = 0 in cycle 4.
- Starvation, STARVE_MAX = 4: buffer holds r9 while `wb_req` is continuously asserted -> writeback writes in cycles 1-4.
  - Cycle 5: `stall_req` = 1 and r9 is written.
  - Cycle 6: the stalled writeback request is written and `stall_req` = 0.
- Same-cycle issue and drain of r3 -> `pending[3]` stays 1. The r0 cases: `wb_addr` = 0 with the buffer valid drains the buffer with no stall, and `md_issue` to r0 leaves busy at 0.
